sdram_arb: RTL

SDRAM_ARB -- requirements
Module: sdram_arb

---
 rtl/sdram_pkg.sv | 20 ++
 rtl/sdram_refresh_tmr.sv | 51 +++++
 rtl/sdram_arb.sv | 127 ++++++++++++
 3 files changed

// File: rtl/sdram_pkg.sv
// Command and FSM encodings shared by the SDRAM arbiter and the SDRAM engine.
package sdram_pkg;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_WRITE   = 2'd1,
    OP_REFRESH = 2'd2,
    OP_VIDEO   = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  localparam int REF_PEND_W = 3;
  localparam logic [REF_PEND_W-1:0] REF_PEND_MAX = '1;

endpackage

// File: rtl/sdram_refresh_tmr.sv
// Free-running refresh timer with a saturating pending-refresh counter.
// A wrap and a grant landing on the same edge cancel each other out.
module sdram_refresh_tmr
  import sdram_pkg::*;
#(
  parameter int REF_PERIOD = 780
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  ref_grant_i,
  output logic [REF_PEND_W-1:0] ref_pend_o,
  output logic                  ref_overrun_o
);

  localparam int TMR_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REF_PERIOD - 1);

  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [REF_PEND_W-1:0] pend_q, pend_d;
  logic                  overrun_q, overrun_d;
  logic                  wrap;

  always_comb begin
    wrap      = (timer_q == TMR_LAST);
    timer_d   = wrap ? '0 : timer_q + 1'b1;
    pend_d    = pend_q;
    overrun_d = overrun_q;
    if (wrap && !ref_grant_i) begin
      if (pend_q == REF_PEND_MAX) overrun_d = 1'b1;
      else                        pend_d    = pend_q + 1'b1;
    end else if (!wrap && ref_grant_i) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer_q   <= '0;
      pend_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
    end
  end

  assign ref_pend_o    = pend_q;
  assign ref_overrun_o = overrun_q;

endmodule

// File: rtl/sdram_arb.sv
// Three-way SDRAM arbiter (refresh > starved CPU > video > CPU) feeding a
// valid/ready command port; one command in flight, held until cmd_done.
module sdram_arb
  import sdram_pkg::*;
#(
  parameter int ADDR_W      = 26,
  parameter int DATA_W      = 16,
  parameter int REF_PERIOD  = 780,
  parameter int CPU_MAXWAIT = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_ack,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [1:0]        cmd_op,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_done,
  output logic              busy,
  output logic              ref_overrun
);

  localparam int WAIT_W = (CPU_MAXWAIT > 0) ? $clog2(CPU_MAXWAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CPU_MAXWAIT);

  arb_state_e            state_q;
  cmd_op_e               cmd_op_q;
  logic                  cmd_valid_q;
  logic [ADDR_W-1:0]     cmd_addr_q;
  logic [DATA_W-1:0]     cmd_data_q;
  logic                  vid_ack_q, cpu_ack_q;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [REF_PEND_W-1:0] ref_pend;
  logic                  idle, cpu_starved, gnt_ref, gnt_cpu, gnt_vid;

  sdram_refresh_tmr #(
    .REF_PERIOD (REF_PERIOD)
  ) u_tmr (
    .clock         (clock),
    .reset_n       (reset_n),
    .ref_grant_i   (gnt_ref),
    .ref_pend_o    (ref_pend),
    .ref_overrun_o (ref_overrun)
  );

  assign idle        = (state_q == ST_IDLE);
  assign cpu_starved = cpu_req && (wait_q == WAIT_MAX);
  assign gnt_ref     = idle && (ref_pend != '0);
  assign gnt_cpu     = idle && !gnt_ref && cpu_req && (cpu_starved || !vid_req);
  assign gnt_vid     = idle && !gnt_ref && !cpu_starved && vid_req;

  // Starvation count only tracks a CPU request that is still being held.
  always_comb begin
    wait_d = wait_q;
    if (!cpu_req || gnt_cpu) wait_d = '0;
    else if (gnt_vid && (wait_q != WAIT_MAX)) wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_op_q    <= OP_READ;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      vid_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      wait_q      <= '0;
    end else begin
      vid_ack_q <= 1'b0;
      cpu_ack_q <= 1'b0;
      wait_q    <= wait_d;
      case (state_q)
        ST_IDLE: begin
          if (gnt_ref || gnt_cpu || gnt_vid) begin
            state_q     <= ST_ISSUE;
            cmd_valid_q <= 1'b1;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            if (gnt_ref) begin
              cmd_op_q <= OP_REFRESH;
            end else if (gnt_cpu) begin
              cmd_op_q   <= cpu_we ? OP_WRITE : OP_READ;
              cmd_addr_q <= cpu_addr;
              if (cpu_we) cmd_data_q <= cpu_data;
              cpu_ack_q  <= 1'b1;
            end else begin
              cmd_op_q   <= OP_VIDEO;
              cmd_addr_q <= vid_addr;
              vid_ack_q  <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (cmd_ready) begin
            state_q     <= ST_WAIT;
            cmd_valid_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cmd_done) state_q <= ST_IDLE;
        end
        default: begin
          state_q     <= ST_IDLE;
          cmd_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = cmd_op_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_data  = cmd_data_q;
  assign vid_ack   = vid_ack_q;
  assign cpu_ack   = cpu_ack_q;

endmodule
